// File: rtl/servo_pkg.sv
// Shared widths, default tuning constants and FSM encoding for the servo
// position ramp (angle command -> slewed PWM duty code).
package servo_pkg;

  localparam int DUTY_W  = 13;
  localparam int ANGLE_W = 8;

  localparam int DUTY_MIN_DEF  = 819;
  localparam int DUTY_MAX_DEF  = 1638;
  localparam int SCALE_Q8_DEF  = 1165;
  localparam int STEP_DEF      = 16;
  localparam int ANGLE_MAX_DEF = 180;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV1 = 2'd1,
    CONV2 = 2'd2,
    RAMP  = 2'd3
  } state_t;

  function automatic int duty_center(input int lo, input int hi);
    return (lo + hi) / 2;
  endfunction

  localparam int DUTY_CENTER = duty_center(DUTY_MIN_DEF, DUTY_MAX_DEF);

endpackage

// File: rtl/servo_angle_to_duty.sv
// Angle-to-duty conversion: registered multiply by the Q8.8 scale, then
// offset by DUTY_MIN and saturate to DUTY_MAX for the caller to latch.
module servo_angle_to_duty
  import servo_pkg::*;
#(
  parameter int DUTY_MIN = DUTY_MIN_DEF,
  parameter int DUTY_MAX = DUTY_MAX_DEF,
  parameter int SCALE_Q8 = SCALE_Q8_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_vld,
  input  logic [ANGLE_W-1:0] i_angle,
  output logic               o_vld,
  output logic [DUTY_W-1:0]  o_duty
);

  // Sized from the operands: 180 * 1165 already needs 18 bits.
  localparam int PROD_W = ANGLE_W + $clog2(SCALE_Q8 + 1);

  logic              r_vld_p1;
  logic [PROD_W-1:0] r_prod_p1;
  logic [PROD_W-1:0] w_sum_p2;

  function automatic logic [DUTY_W-1:0] sat_duty(input logic [PROD_W-1:0] sum);
    if (sum > PROD_W'(DUTY_MAX)) return DUTY_W'(DUTY_MAX);
    return DUTY_W'(sum);
  endfunction

  // p1: product register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_vld_p1 <= 1'b0;
    else          r_vld_p1 <= i_vld;
  end

  always_ff @(posedge i_clk) begin
    if (i_vld) r_prod_p1 <= PROD_W'(i_angle) * PROD_W'(SCALE_Q8);
  end

  // p2: drop the Q8 fraction, add offset, saturate
  assign w_sum_p2 = PROD_W'(DUTY_MIN) + (r_prod_p1 >> 8);
  assign o_vld    = r_vld_p1;
  assign o_duty   = sat_duty(w_sum_p2);

endmodule

// File: rtl/servo_position_ramp.sv
// Command stage for the servo PWM: accepts angle commands, converts them to
// a duty target and slews oDUTY toward it by at most STEP per PWM frame.
module servo_position_ramp
  import servo_pkg::*;
#(
  parameter int DUTY_MIN  = DUTY_MIN_DEF,
  parameter int DUTY_MAX  = DUTY_MAX_DEF,
  parameter int SCALE_Q8  = SCALE_Q8_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int ANGLE_MAX = ANGLE_MAX_DEF
) (
  input  logic               iCLK,
  input  logic               iRESETn,
  input  logic               iCMD_VALID,
  input  logic [ANGLE_W-1:0] iCMD_ANGLE,
  output logic               oCMD_READY,
  input  logic               iFRAME_TICK,
  input  logic               iHOLD,
  output logic [DUTY_W-1:0]  oDUTY,
  output logic               oAT_TARGET,
  output logic               oBUSY
);

  localparam logic [DUTY_W-1:0]   C_CENTER = DUTY_W'(duty_center(DUTY_MIN, DUTY_MAX));
  localparam logic [DUTY_W-1:0]   C_STEP   = DUTY_W'(STEP);
  localparam logic signed [DUTY_W:0] C_STEP_S = (DUTY_W+1)'(STEP);

  state_t             r_state, w_state_nxt;
  logic [ANGLE_W-1:0] r_angle;
  logic [DUTY_W-1:0]  r_duty, w_duty_nxt;
  logic [DUTY_W-1:0]  r_target, w_target_nxt;
  logic [DUTY_W-1:0]  w_step, w_conv_duty;
  logic               r_at_target;
  logic               w_ready, w_accept, w_conv_vld;

  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
    if (a > ANGLE_W'(ANGLE_MAX)) return ANGLE_W'(ANGLE_MAX);
    return a;
  endfunction

  // One bounded move toward tgt; lands exactly on tgt when within STEP.
  function automatic logic [DUTY_W-1:0] slew_step(input logic [DUTY_W-1:0] cur,
                                                 input logic [DUTY_W-1:0] tgt);
    logic signed [DUTY_W:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > C_STEP_S)  return cur + C_STEP;
    if (diff < -C_STEP_S) return cur - C_STEP;
    return tgt;
  endfunction

  assign w_ready  = (r_state == IDLE) || (r_state == RAMP);
  assign w_accept = iCMD_VALID && w_ready;
  assign w_step   = slew_step(r_duty, r_target);

  servo_angle_to_duty #(
    .DUTY_MIN (DUTY_MIN),
    .DUTY_MAX (DUTY_MAX),
    .SCALE_Q8 (SCALE_Q8)
  ) u_conv (
    .i_clk   (iCLK),
    .i_rst_n (iRESETn),
    .i_vld   (r_state == CONV1),
    .i_angle (r_angle),
    .o_vld   (w_conv_vld),
    .o_duty  (w_conv_duty)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_duty_nxt   = r_duty;
    w_target_nxt = r_target;
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = CONV1;
      CONV1: w_state_nxt = CONV2;
      CONV2: begin
        if (w_conv_vld) w_target_nxt = w_conv_duty;
        w_state_nxt = (w_conv_duty == r_duty) ? IDLE : RAMP;
      end
      RAMP: begin
        // A tick and a new command in one cycle: step toward the old target first.
        if (iFRAME_TICK && !iHOLD) begin
          w_duty_nxt = w_step;
          if (w_step == r_target) w_state_nxt = IDLE;
        end
        if (w_accept) w_state_nxt = CONV1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_state     <= IDLE;
      r_duty      <= C_CENTER;
      r_target    <= C_CENTER;
      r_at_target <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_duty      <= w_duty_nxt;
      r_target    <= w_target_nxt;
      r_at_target <= (w_duty_nxt == w_target_nxt);
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_accept) r_angle <= clamp_angle(iCMD_ANGLE);
  end

  assign oCMD_READY = w_ready;
  assign oDUTY      = r_duty;
  assign oAT_TARGET = r_at_target;
  assign oBUSY      = (r_state != IDLE);

endmodule
